// File: rtl/brq_regout_pkg.sv
// rtl/brq_regout_pkg.sv - shared types and constants for the Reg_Out UART transmitter
package brq_regout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_WIDTH     = 32;
  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam int BIT_IDX_W      = 3;

endpackage

// File: rtl/brq_uart_byte_tx.sv
// rtl/brq_uart_byte_tx.sv - one 8N1 UART byte with its own baud counter
module brq_uart_byte_tx
  import brq_regout_pkg::*;
#(
  parameter int ClkPerBit = 868
) (
  input  logic       brq_clk,
  input  logic       brq_rst_n,
  input  logic [7:0] byte_i,
  input  logic       start_i,
  output logic       done_o,
  output logic       tx_o
);

  localparam int CntW = $clog2(ClkPerBit);
  localparam logic [CntW-1:0] CntLast = CntW'(ClkPerBit - 1);

  tx_state_e              state_q;
  logic [CntW-1:0]        cnt_q;
  logic [BIT_IDX_W-1:0]   bit_q;
  logic [7:0]             shift_q;
  logic                   tx_q;
  logic                   wrap;

  assign wrap   = (cnt_q == CntLast);
  // start_i is honoured in IDLE and on the final STOP cycle so bytes chain with no gap
  assign done_o = (state_q == STOP) && wrap;
  assign tx_o   = tx_q;

  always_ff @(posedge brq_clk or negedge brq_rst_n) begin
    if (!brq_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      if (state_q != IDLE) begin
        cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            shift_q <= byte_i;
            tx_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (wrap) begin
            tx_q    <= shift_q[0];
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (wrap) begin
            if (bit_q == '1) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[1];
              shift_q <= shift_q >> 1;
            end
          end
        end
        STOP: begin
          if (wrap) begin
            if (start_i) begin
              shift_q <= byte_i;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/brq_regout_tx.sv
// rtl/brq_regout_tx.sv - sends captured Reg_Out words as four 8N1 bytes, LSB first
// Define BRQ_REGOUT_CHANGE_DETECT_EN to also capture whenever reg_out_i changes.
module brq_regout_tx
  import brq_regout_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH,
  parameter int ClkPerBit = 868
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst_n,
  input  logic [DataWidth-1:0] reg_out_i,
  input  logic                 reg_valid_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 drop_o
);

  localparam int Bytes = DataWidth / 8;
  localparam int IdxW  = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Bytes - 1);

  logic                 active_q;
  logic [IdxW-1:0]      byte_idx_q;
  logic [DataWidth-1:0] shift_q;
  logic [DataWidth-1:0] hold_q;
  logic                 hold_full_q;

  logic                 cap;
  logic                 byte_done;
  logic                 start;
  logic [DataWidth-1:0] load_word;
  logic [IdxW-1:0]      load_idx;
  logic                 cap_direct;
  logic                 hold_pop;
  logic                 word_end;
  logic                 cap_to_hold;
  logic                 drop;
  logic [7:0]           byte_sel;

`ifdef BRQ_REGOUT_CHANGE_DETECT_EN
  logic [DataWidth-1:0] last_q;

  assign cap = reg_valid_i | (reg_out_i != last_q);

  always_ff @(posedge brq_clk or negedge brq_rst_n) begin
    if (!brq_rst_n) begin
      last_q <= '0;
    end else if (cap && !drop) begin
      last_q <= reg_out_i;
    end
  end
`else
  assign cap = reg_valid_i;
`endif

  // Decide what, if anything, the byte transmitter starts on this cycle.
  always_comb begin
    start      = 1'b0;
    load_word  = shift_q;
    load_idx   = byte_idx_q;
    cap_direct = 1'b0;
    hold_pop   = 1'b0;
    word_end   = 1'b0;
    if (!active_q) begin
      if (cap) begin
        start      = 1'b1;
        load_word  = reg_out_i;
        load_idx   = '0;
        cap_direct = 1'b1;
      end
    end else if (byte_done) begin
      if (byte_idx_q != LastIdx) begin
        start    = 1'b1;
        load_idx = byte_idx_q + 1'b1;
      end else if (hold_full_q) begin
        start     = 1'b1;
        load_word = hold_q;
        load_idx  = '0;
        hold_pop  = 1'b1;
      end else if (cap) begin
        start      = 1'b1;
        load_word  = reg_out_i;
        load_idx   = '0;
        cap_direct = 1'b1;
      end else begin
        word_end = 1'b1;
      end
    end
  end

  // A hold slot freed on this edge can accept the new value, so no drop then.
  assign cap_to_hold = cap && !cap_direct && (!hold_full_q || hold_pop);
  assign drop        = cap && !cap_direct && hold_full_q && !hold_pop;
  assign byte_sel    = load_word[{load_idx, 3'b000} +: 8];

  always_ff @(posedge brq_clk or negedge brq_rst_n) begin
    if (!brq_rst_n) begin
      active_q    <= 1'b0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (start) begin
        active_q   <= 1'b1;
        shift_q    <= load_word;
        byte_idx_q <= load_idx;
      end else if (word_end) begin
        active_q   <= 1'b0;
        byte_idx_q <= '0;
      end
      if (cap_to_hold) begin
        hold_q      <= reg_out_i;
        hold_full_q <= 1'b1;
      end else if (hold_pop) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  brq_uart_byte_tx #(
    .ClkPerBit(ClkPerBit)
  ) u_byte_tx (
    .brq_clk  (brq_clk),
    .brq_rst_n(brq_rst_n),
    .byte_i   (byte_sel),
    .start_i  (start),
    .done_o   (byte_done),
    .tx_o     (tx_o)
  );

  assign busy_o = active_q;
  assign drop_o = drop;

endmodule
